// File: rtl/wb_decoder.sv
// Wishbone classic single-master address decoder and response multiplexer.
// Routes one master to N slaves and raises err for unmapped addresses and unacknowledged cycles.
module wb_decoder #(
   parameter int unsigned              N_SLAVES   = 3,
   parameter logic [32*N_SLAVES-1:0]   BASE_ADDRS = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000},
   parameter logic [32*N_SLAVES-1:0]   SIZES      = {32'h0000_1000, 32'h0000_4000, 32'h0020_0000},
   parameter int unsigned              TIMEOUT    = 255
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       m_cyc_i,
   input  logic                       m_stb_i,
   input  logic                       m_we_i,
   input  logic [31:0]                m_adr_i,
   input  logic [3:0]                 m_sel_i,
   input  logic [31:0]                m_dat_i,
   output logic [31:0]                m_dat_o,
   output logic                       m_ack_o,
   output logic                       m_err_o,
   output logic                       m_rty_o,
   output logic [N_SLAVES-1:0]        s_cyc_o,
   output logic [N_SLAVES-1:0]        s_stb_o,
   output logic                       s_we_o,
   output logic [31:0]                s_adr_o,
   output logic [3:0]                 s_sel_o,
   output logic [31:0]                s_dat_o,
   input  logic [32*N_SLAVES-1:0]     s_dat_i,
   input  logic [N_SLAVES-1:0]        s_ack_i,
   input  logic [N_SLAVES-1:0]        s_err_i,
   input  logic [N_SLAVES-1:0]        s_rty_i
);

   localparam int unsigned IDX_W  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
   localparam int unsigned WD_RAW = $clog2(64'(TIMEOUT) + 64'd1);
   localparam int unsigned WDOG_W = (WD_RAW < 8) ? 8 : ((WD_RAW > 32) ? 32 : WD_RAW);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      ERR    = 2'd2,
      TOUT   = 2'd3
   } state_t;

   state_t              state;
   logic [IDX_W-1:0]    sel_idx;
   logic [WDOG_W-1:0]   wdog;

   logic                hit;
   logic [IDX_W-1:0]    hit_idx;
   logic [N_SLAVES-1:0] sel_onehot;
   logic                sel_ack;
   logic                sel_err;
   logic                sel_rty;
   logic [31:0]         sel_dat;
   logic                sel_resp;

   // Window test done in 33 bits so a window ending at 4 GiB does not wrap.
   function automatic logic in_window(input logic [31:0] adr,
                                      input logic [31:0] base,
                                      input logic [31:0] size);
      logic [32:0] a;
      logic [32:0] lo;
      logic [32:0] hi;
      a  = {1'b0, adr};
      lo = {1'b0, base};
      hi = lo + {1'b0, size};
      return (a >= lo) && (a < hi);
   endfunction

   // Address decode; scanning downwards lets the lowest index win on overlap.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
         if (in_window(m_adr_i, BASE_ADDRS[32*i +: 32], SIZES[32*i +: 32])) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   // Pick the registered slave's response lines.
   always_comb begin
      sel_onehot = '0;
      sel_ack    = 1'b0;
      sel_err    = 1'b0;
      sel_rty    = 1'b0;
      sel_dat    = '0;
      for (int i = 0; i < int'(N_SLAVES); i++) begin
         if (sel_idx == IDX_W'(i)) begin
            sel_onehot[i] = 1'b1;
            sel_ack       = s_ack_i[i];
            sel_err       = s_err_i[i];
            sel_rty       = s_rty_i[i];
            sel_dat       = s_dat_i[32*i +: 32];
         end
      end
   end

   assign sel_resp = sel_ack | sel_err | sel_rty;

   // Control FSM, watchdog and latched broadcast fields.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         sel_idx <= '0;
         wdog    <= '0;
         s_we_o  <= 1'b0;
         s_adr_o <= '0;
         s_sel_o <= '0;
         s_dat_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (m_cyc_i && m_stb_i) begin
                  sel_idx <= hit_idx;
                  s_we_o  <= m_we_i;
                  s_adr_o <= m_adr_i;
                  s_sel_o <= m_sel_i;
                  s_dat_o <= m_dat_i;
                  wdog    <= '0;
                  state   <= hit ? ACTIVE : ERR;
               end
            end
            ACTIVE: begin
               if (!m_cyc_i || sel_resp) begin
                  state <= IDLE;
               end else if ((TIMEOUT != 0) && (wdog == WDOG_W'(TIMEOUT))) begin
                  state <= TOUT;
               end else begin
                  wdog <= wdog + WDOG_W'(1);
               end
            end
            ERR:     state <= IDLE;
            TOUT:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Strobes and master responses decode from state; an aborted cycle drops them at once.
   always_comb begin
      s_cyc_o = '0;
      s_stb_o = '0;
      m_ack_o = 1'b0;
      m_err_o = 1'b0;
      m_rty_o = 1'b0;
      m_dat_o = '0;
      case (state)
         ACTIVE: begin
            m_dat_o = sel_dat;
            if (m_cyc_i) begin
               s_cyc_o = sel_onehot;
               s_stb_o = sel_onehot;
               m_err_o = sel_err;
               m_rty_o = sel_rty & ~sel_err;
               m_ack_o = sel_ack & ~sel_err & ~sel_rty;
            end
         end
         ERR:     m_err_o = 1'b1;
         TOUT:    m_err_o = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_decoder.sv
// Directed bench for wb_decoder: vector table of single transactions against
// programmable slave responders, plus abort and mid-cycle reset sequences.
module tb_wb_decoder;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        m_cyc_i, m_stb_i, m_we_i;
   logic [31:0] m_adr_i, m_dat_i;
   logic [3:0]  m_sel_i;
   logic [31:0] m_dat_o;
   logic        m_ack_o, m_err_o, m_rty_o;
   logic [2:0]  s_cyc_o, s_stb_o;
   logic        s_we_o;
   logic [31:0] s_adr_o, s_dat_o;
   logic [3:0]  s_sel_o;
   logic [95:0] s_dat_i;
   logic [2:0]  s_ack_i, s_err_i, s_rty_i;

   int n_tests = 0;
   int n_fail  = 0;

   // Responder config per slave: kind bits {rty, err, ack}; dly = strobed edges before responding.
   logic [2:0] kind [3];
   int         dly  [3];
   int         cnt  [3];
   logic       resp [3];

   typedef struct {
      logic [31:0] adr;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] wdat;
      int          slv;
      logic [2:0]  kind;
      int          dly;
      logic [2:0]  exp_resp;   // {err, rty, ack}
      int          exp_lat;
      int          exp_stb;
      logic [31:0] exp_dat;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   always #5 clk_i = ~clk_i;

   assign s_dat_i = {32'h0BAD_0002, 32'hCAFE_0001, 32'hDEAD_BEEF};

   wb_decoder #(.TIMEOUT(4)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .m_cyc_i (m_cyc_i),
      .m_stb_i (m_stb_i),
      .m_we_i  (m_we_i),
      .m_adr_i (m_adr_i),
      .m_sel_i (m_sel_i),
      .m_dat_i (m_dat_i),
      .m_dat_o (m_dat_o),
      .m_ack_o (m_ack_o),
      .m_err_o (m_err_o),
      .m_rty_o (m_rty_o),
      .s_cyc_o (s_cyc_o),
      .s_stb_o (s_stb_o),
      .s_we_o  (s_we_o),
      .s_adr_o (s_adr_o),
      .s_sel_o (s_sel_o),
      .s_dat_o (s_dat_o),
      .s_dat_i (s_dat_i),
      .s_ack_i (s_ack_i),
      .s_err_i (s_err_i),
      .s_rty_i (s_rty_i)
   );

   // Registered slave responders: respond after dly strobed edges, hold until strobe drops.
   always @(posedge clk_i) begin
      for (int i = 0; i < 3; i++) begin
         if (s_cyc_o[i] && s_stb_o[i]) begin
            if (resp[i]) begin
               resp[i] <= 1'b0;
               cnt[i]  <= 0;
            end else if (kind[i] != 3'b000 && cnt[i] + 1 >= dly[i]) begin
               resp[i] <= 1'b1;
            end else begin
               cnt[i] <= cnt[i] + 1;
            end
         end else begin
            resp[i] <= 1'b0;
            cnt[i]  <= 0;
         end
      end
   end

   always_comb begin
      s_ack_i = '0;
      s_err_i = '0;
      s_rty_i = '0;
      for (int i = 0; i < 3; i++) begin
         s_ack_i[i] = resp[i] & kind[i][0];
         s_err_i[i] = resp[i] & kind[i][1];
         s_rty_i[i] = resp[i] & kind[i][2];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic set_slaves(input int slv, input logic [2:0] k, input int d);
      for (int i = 0; i < 3; i++) begin
         kind[i] = 3'b000;
         dly[i]  = 1;
      end
      kind[slv] = k;
      dly[slv]  = d;
   endtask

   task automatic drive_req(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                            input logic [31:0] wdat);
      m_cyc_i = 1'b1;
      m_stb_i = 1'b1;
      m_we_i  = we;
      m_adr_i = adr;
      m_sel_i = sel;
      m_dat_i = wdat;
   endtask

   task automatic drop_req();
      m_cyc_i = 1'b0;
      m_stb_i = 1'b0;
      m_we_i  = 1'b0;
   endtask

   function automatic logic [31:0] ctl_bits();
      return 32'({s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_rty_o});
   endfunction

   // One master transaction; latency counted in negedges after the request is presented.
   task automatic run_txn(input vec_t v, input string tag);
      logic        got;
      logic        bad_hot;
      int          lat;
      int          stb_n;
      logic [2:0]  resp_seen;
      logic [31:0] dat_seen;
      logic [31:0] adr_seen, wd_seen;
      logic [3:0]  sel_seen;
      logic        we_seen;
      got = 1'b0; bad_hot = 1'b0; lat = 0; stb_n = 0;
      resp_seen = '0; dat_seen = '0; adr_seen = '0; wd_seen = '0; sel_seen = '0; we_seen = 1'b0;
      set_slaves(v.slv, v.kind, v.dly);
      @(negedge clk_i);
      drive_req(v.adr, v.we, v.sel, v.wdat);
      for (int c = 1; c <= 40 && !got; c++) begin
         @(negedge clk_i);
         if (s_stb_o != 3'b000) begin
            stb_n++;
            if (s_stb_o != 3'(1 << v.slv) || s_cyc_o != s_stb_o) bad_hot = 1'b1;
            if (stb_n == 1) begin
               adr_seen = s_adr_o; wd_seen = s_dat_o; sel_seen = s_sel_o; we_seen = s_we_o;
            end
         end
         if (m_ack_o || m_err_o || m_rty_o) begin
            got       = 1'b1;
            lat       = c;
            resp_seen = {m_err_o, m_rty_o, m_ack_o};
            dat_seen  = m_dat_o;
         end
      end
      drop_req();
      check({tag, "_got_resp"}, 32'(got), 32'd1);
      check({tag, "_resp"}, 32'(resp_seen), 32'(v.exp_resp));
      check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
      check({tag, "_stb_cycles"}, 32'(stb_n), 32'(v.exp_stb));
      check({tag, "_stb_onehot"}, 32'(bad_hot), 32'd0);
      check({tag, "_rdata"}, dat_seen, v.exp_dat);
      if (v.exp_stb > 0) begin
         check({tag, "_s_adr"}, adr_seen, v.adr);
         check({tag, "_s_sel"}, 32'(sel_seen), 32'(v.sel));
         check({tag, "_s_we"}, 32'(we_seen), 32'(v.we));
         check({tag, "_s_dat"}, wd_seen, v.wdat);
      end
      @(negedge clk_i);
      check({tag, "_post_ctl"}, ctl_bits(), 32'd0);
      check({tag, "_post_dat"}, m_dat_o, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      vec_t v;
      logic any_resp;
      //             adr           we    sel      wdat          slv kind    dly resp    lat stb dat
      vecs[0]  = '{32'h1000_0004, 1'b0, 4'hF,   32'h0,         0, 3'b001, 1, 3'b001, 2, 2, 32'hDEAD_BEEF};
      vecs[1]  = '{32'h2000_3FFC, 1'b1, 4'b0011,32'h1234_5678, 1, 3'b001, 1, 3'b001, 2, 2, 32'hCAFE_0001};
      vecs[2]  = '{32'h2000_4000, 1'b1, 4'hF,   32'hAAAA_5555, 1, 3'b001, 1, 3'b100, 1, 0, 32'h0};
      vecs[3]  = '{32'h3000_0000, 1'b0, 4'hF,   32'h0,         2, 3'b000, 1, 3'b100, 6, 5, 32'h0};
      vecs[4]  = '{32'h2000_0010, 1'b0, 4'hF,   32'h0,         1, 3'b011, 1, 3'b100, 2, 2, 32'hCAFE_0001};
      vecs[5]  = '{32'h101F_FFFC, 1'b0, 4'hF,   32'h0,         0, 3'b001, 3, 3'b001, 4, 4, 32'hDEAD_BEEF};
      vecs[6]  = '{32'h1020_0000, 1'b0, 4'hF,   32'h0,         0, 3'b001, 1, 3'b100, 1, 0, 32'h0};
      vecs[7]  = '{32'h0FFF_FFFC, 1'b0, 4'hF,   32'h0,         0, 3'b001, 1, 3'b100, 1, 0, 32'h0};
      vecs[8]  = '{32'h3000_0FFC, 1'b1, 4'b1100,32'h0F0F_0F0F, 2, 3'b100, 1, 3'b010, 2, 2, 32'h0BAD_0002};
      vecs[9]  = '{32'h2000_0000, 1'b0, 4'hF,   32'h0,         1, 3'b101, 2, 3'b010, 3, 3, 32'hCAFE_0001};
      vecs[10] = '{32'h3000_0800, 1'b0, 4'hF,   32'h0,         2, 3'b110, 1, 3'b100, 2, 2, 32'h0BAD_0002};
      vecs[11] = '{32'h3000_1000, 1'b0, 4'hF,   32'h0,         2, 3'b001, 1, 3'b100, 1, 0, 32'h0};
      vecs[12] = '{32'hFFFF_FFFC, 1'b0, 4'hF,   32'h0,         0, 3'b001, 1, 3'b100, 1, 0, 32'h0};

      rst_i = 1'b1;
      drop_req();
      m_adr_i = '0; m_sel_i = '0; m_dat_i = '0;
      set_slaves(0, 3'b000, 1);
      @(negedge clk_i);
      @(negedge clk_i);
      check("reset_ctl", ctl_bits(), 32'd0);
      check("reset_dat", m_dat_o, 32'd0);
      check("reset_s_adr", s_adr_o, 32'd0);
      rst_i = 1'b0;
      @(negedge clk_i);
      check("idle_ctl", ctl_bits(), 32'd0);

      for (int i = 0; i < NV; i++) run_txn(vecs[i], $sformatf("v%0d", i));

      // Master abandons a cycle to the non-responding slave.
      set_slaves(2, 3'b000, 1);
      @(negedge clk_i);
      drive_req(32'h3000_0008, 1'b0, 4'hF, 32'h0);
      any_resp = 1'b0;
      repeat (2) begin
         @(negedge clk_i);
         any_resp = any_resp | m_ack_o | m_err_o | m_rty_o;
      end
      check("abort_stb_active", 32'(s_stb_o), 32'h4);
      drop_req();
      @(negedge clk_i);
      any_resp = any_resp | m_ack_o | m_err_o | m_rty_o;
      check("abort_ctl", ctl_bits(), 32'd0);
      check("abort_dat", m_dat_o, 32'd0);
      @(negedge clk_i);
      any_resp = any_resp | m_ack_o | m_err_o | m_rty_o;
      check("abort_no_resp", 32'(any_resp), 32'd0);
      v = '{32'h1000_0100, 1'b0, 4'hF, 32'h0, 0, 3'b001, 1, 3'b001, 2, 2, 32'hDEAD_BEEF};
      run_txn(v, "after_abort");

      // Reset pulsed while a cycle is outstanding.
      set_slaves(2, 3'b000, 1);
      @(negedge clk_i);
      drive_req(32'h3000_0010, 1'b1, 4'hF, 32'h5555_AAAA);
      repeat (2) @(negedge clk_i);
      check("rstmid_stb_active", 32'(s_stb_o), 32'h4);
      rst_i = 1'b1;
      #1;
      check("rstmid_ctl", ctl_bits(), 32'd0);
      check("rstmid_dat", m_dat_o, 32'd0);
      @(negedge clk_i);
      drop_req();
      rst_i = 1'b0;
      @(negedge clk_i);
      check("rstmid_idle_ctl", ctl_bits(), 32'd0);
      check("rstmid_s_adr", s_adr_o, 32'd0);
      v = '{32'h2000_0ABC, 1'b1, 4'b0101, 32'h0BEE_F00D, 1, 3'b001, 2, 3'b001, 3, 3, 32'hCAFE_0001};
      run_txn(v, "after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
